// File: rtl/row_loader_pkg.sv
// Shared definitions for the row-load command parser.
// Holds the command byte that opens a row frame, the parser state encoding
// and the default framebuffer geometry (rows x columns).
package row_loader_pkg;

    // Command byte that opens a row-load frame ('L').
    localparam logic [7:0] CMD_ROW = 8'h4C;

    // Framebuffer geometry: 32 rows of 64 pixels.
    localparam int DEFAULT_ROW_BITS = 5;
    localparam int DEFAULT_COL_BITS = 6;

    // Parser state encoding.
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ROW    = 2'd1;
    localparam logic [1:0] STATE_PIX_HI = 2'd2;
    localparam logic [1:0] STATE_PIX_LO = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = STATE_IDLE,
        ROW    = STATE_ROW,
        PIX_HI = STATE_PIX_HI,
        PIX_LO = STATE_PIX_LO
    } state_t;

endpackage

// File: rtl/row_loader_timeout_counter.sv
// Inter-byte idle counter for the row-load parser.
// Ports:
//   clk_in  - system clock
//   reset   - synchronous, active-high
//   clear   - forces the count to zero next cycle (has priority over enable)
//   enable  - increments the count by one
//   expired - high while the count equals TIMEOUT_TICKS
module timeout_counter
    import row_loader_pkg::*;
#(
    parameter int                       TIMEOUT_WIDTH = 12,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 12'd4000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic [TIMEOUT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The parser leaves its frame states on expiry, which clears the count,
    // so the counter never runs past TIMEOUT_TICKS.
    assign expired = (count_q == TIMEOUT_TICKS);

endmodule

// File: rtl/row_loader.sv
// Receive-side row-load frame parser for the LED panel controller.
// Frame: CMD_ROW, row index, then 2^COL_BITS pixels as big-endian 16-bit
// words. Each completed pixel becomes one framebuffer write.
// Ports:
//   clk_in           - system clock
//   reset            - synchronous, active-high
//   rx_data          - received byte
//   rx_data_valid    - one-cycle strobe qualifying rx_data
//   ram_write_enable - one-cycle framebuffer write strobe
//   ram_address      - {row, column} of the write
//   ram_data         - pixel word {high byte, low byte}
//   row_done         - pulse coincident with the last pixel write of a row
//   frame_error      - pulse on out-of-range row or inter-byte timeout
//   busy             - high whenever the parser is inside a frame
module row_loader #(
    parameter int                       ROW_BITS      = row_loader_pkg::DEFAULT_ROW_BITS,
    parameter int                       COL_BITS      = row_loader_pkg::DEFAULT_COL_BITS,
    parameter logic [7:0]               CMD_ROW       = row_loader_pkg::CMD_ROW,
    parameter int                       TIMEOUT_WIDTH = 12,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 12'd4000
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_data_valid,
    output logic                         ram_write_enable,
    output logic [ROW_BITS+COL_BITS-1:0] ram_address,
    output logic [15:0]                  ram_data,
    output logic                         row_done,
    output logic                         frame_error,
    output logic                         busy
);
    import row_loader_pkg::*;

    localparam int ADDR_W = ROW_BITS + COL_BITS;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [7:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic expired;
    logic tmo_clear;
    logic row_in_range;

    // Out-of-range rows are rejected rather than truncated.
    assign row_in_range = ((rx_data >> ROW_BITS) == 8'd0);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // A byte arriving in the expiry cycle wins over the timeout.
        if (state_q != IDLE && !rx_data_valid && expired) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data_valid && rx_data == CMD_ROW) begin
                        state_d = ROW;
                    end
                end
                ROW: begin
                    if (rx_data_valid) begin
                        if (row_in_range) begin
                            row_d   = rx_data[ROW_BITS-1:0];
                            col_d   = '0;
                            state_d = PIX_HI;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                PIX_HI: begin
                    if (rx_data_valid) begin
                        hi_d    = rx_data;
                        state_d = PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (rx_data_valid) begin
                        we_d   = 1'b1;
                        addr_d = {row_q, col_q};
                        data_d = {hi_q, rx_data};
                        if (col_q == {COL_BITS{1'b1}}) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            col_d   = col_q + COL_BITS'(1);
                            state_d = PIX_HI;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Clearing on the way into IDLE keeps the count at zero while idle.
    assign tmo_clear = rx_data_valid || (state_d == IDLE);

    timeout_counter #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk_in  (clk_in),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (state_q != IDLE),
        .expired (expired)
    );

    assign ram_write_enable = we_q;
    assign ram_address      = addr_q;
    assign ram_data         = data_q;
    assign row_done         = done_q;
    assign frame_error      = err_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_row_loader.sv
// Self-checking bench for row_loader: a vector table, directed multi-cycle
// corner cases and randomized frames checked against a byte-stream model.
module tb_row_loader;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        ram_write_enable;
    logic [10:0] ram_address;
    logic [15:0] ram_data;
    logic        row_done;
    logic        frame_error;
    logic        busy;

    always #5 clk_in = ~clk_in;

    row_loader dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_data_valid    (rx_data_valid),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data         (ram_data),
        .row_done         (row_done),
        .frame_error      (frame_error),
        .busy             (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: tracks the frame as a count of payload bytes.
    bit          m_active;
    bit          m_got_row;
    int          m_row;
    int          m_nbytes;
    int          m_idle;
    logic [7:0]  m_hi;
    logic        exp_we, exp_done, exp_err;
    logic [10:0] exp_addr;
    logic [15:0] exp_data;

    // Observed statistics per scenario.
    int          n_writes, n_errs, n_done;
    logic [10:0] first_addr, last_addr, done_addr;
    logic [15:0] last_data;

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [10:0] addr;
        logic [15:0] data;
        logic        busy;
        logic        err;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        int pix;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_idle   = 0;
            exp_addr = '0;
            exp_data = '0;
            return;
        end
        if (!m_active) begin
            if (v && d == 8'h4C) begin
                m_active  = 1'b1;
                m_got_row = 1'b0;
                m_nbytes  = 0;
                m_idle    = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (!m_got_row) begin
                if (d < 8'd32) begin
                    m_row     = int'(d);
                    m_got_row = 1'b1;
                    m_nbytes  = 0;
                end else begin
                    exp_err  = 1'b1;
                    m_active = 1'b0;
                end
            end else begin
                m_nbytes++;
                if (m_nbytes % 2 == 1) begin
                    m_hi = d;
                end else begin
                    pix      = m_nbytes / 2 - 1;
                    exp_we   = 1'b1;
                    exp_addr = 11'(m_row * 64 + pix);
                    exp_data = {m_hi, d};
                    if (pix == 63) begin
                        exp_done = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
        end else begin
            m_idle++;
            if (m_idle > 4000) begin
                exp_err  = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic clear_stats();
        n_writes   = 0;
        n_errs     = 0;
        n_done     = 0;
        first_addr = '0;
        last_addr  = '0;
        done_addr  = '0;
        last_data  = '0;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        reset         = r;
        rx_data_valid = v;
        rx_data       = d;
        @(posedge clk_in);
        model_step(r, v, d);
        #1;
        check("write_enable", 32'(ram_write_enable), 32'(exp_we));
        check("address", 32'(ram_address), 32'(exp_addr));
        check("data", 32'(ram_data), 32'(exp_data));
        check("row_done", 32'(row_done), 32'(exp_done));
        check("frame_error", 32'(frame_error), 32'(exp_err));
        check("busy", 32'(busy), 32'(m_active));
        if (ram_write_enable === 1'b1) begin
            if (n_writes == 0) first_addr = ram_address;
            n_writes++;
            last_addr = ram_address;
            last_data = ram_data;
        end
        if (frame_error === 1'b1) n_errs++;
        if (row_done === 1'b1) begin
            n_done++;
            done_addr = ram_address;
        end
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] row, input int gap_max);
        send(8'h4C);
        send(row);
        for (int i = 0; i < 128; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            send(8'($urandom));
        end
    endtask

    initial begin
        m_active  = 1'b0;
        m_got_row = 1'b0;
        m_row     = 0;
        m_nbytes  = 0;
        m_idle    = 0;
        m_hi      = '0;
        clear_stats();

        // Reset state.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);

        // Vector table.
        vecs.push_back('{1'b0, 1'b1, 8'h4C, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h12, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h34, 1'b1, 11'h240, 16'h1234, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h56, 1'b0, 11'h240, 16'h1234, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h78, 1'b1, 11'h241, 16'h5678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 11'h241, 16'h5678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h4C, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h25, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h41, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h4C, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h1F, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hBB, 1'b1, 11'h7C0, 16'hAABB, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].v, vecs[i].d);
            check("tbl_we", 32'(ram_write_enable), 32'(vecs[i].we));
            check("tbl_addr", 32'(ram_address), 32'(vecs[i].addr));
            check("tbl_data", 32'(ram_data), 32'(vecs[i].data));
            check("tbl_busy", 32'(busy), 32'(vecs[i].busy));
            check("tbl_err", 32'(frame_error), 32'(vecs[i].err));
            check("tbl_done", 32'(row_done), 32'(vecs[i].done));
        end

        // Full back-to-back frame on row 3.
        clear_stats();
        send_frame(8'h03, 0);
        check("full_writes", 32'(n_writes), 32'd64);
        check("full_first_addr", 32'(first_addr), 32'h0C0);
        check("full_done_count", 32'(n_done), 32'd1);
        check("full_done_addr", 32'(done_addr), 32'h0FF);
        idle(1);
        check("full_busy_after", 32'(busy), 32'd0);

        // Leading junk then a frame with gaps.
        clear_stats();
        send(8'h00);
        send(8'hFF);
        send(8'h41);
        send_frame(8'h11, 2);
        check("junk_writes", 32'(n_writes), 32'd64);
        check("junk_errs", 32'(n_errs), 32'd0);
        check("junk_first_addr", 32'(first_addr), 32'h440);

        // Timeout after a partial pixel.
        clear_stats();
        send(8'h4C);
        send(8'h02);
        send(8'hAB);
        idle(4005);
        check("tmo_errs", 32'(n_errs), 32'd1);
        check("tmo_writes", 32'(n_writes), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        send_frame(8'h04, 0);
        check("tmo_next_writes", 32'(n_writes), 32'd64);
        check("tmo_next_first", 32'(first_addr), 32'h100);
        check("tmo_next_errs", 32'(n_errs), 32'd1);

        // Byte arriving in the expiry cycle is accepted.
        clear_stats();
        send(8'h4C);
        send(8'h02);
        send(8'hAB);
        idle(4000);
        send(8'hCD);
        check("exp_errs", 32'(n_errs), 32'd0);
        check("exp_writes", 32'(n_writes), 32'd1);
        check("exp_data", 32'(last_data), 32'hABCD);
        check("exp_addr", 32'(last_addr), 32'h080);
        cycle(1'b1, 1'b0, 8'h00);

        // Reset after ten pixels.
        clear_stats();
        send(8'h4C);
        send(8'h05);
        for (int i = 0; i < 20; i++) send(8'(i + 1));
        check("rst_pre_writes", 32'(n_writes), 32'd10);
        clear_stats();
        cycle(1'b1, 1'b0, 8'h00);
        idle(5);
        check("rst_writes", 32'(n_writes), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        send(8'h4C);
        send(8'h06);
        send(8'h12);
        send(8'h34);
        check("rst_next_addr", 32'(first_addr), 32'h180);
        check("rst_next_data", 32'(last_data), 32'h1234);
        cycle(1'b1, 1'b0, 8'h00);

        // Randomized frames including out-of-range rows.
        for (int f = 0; f < 8; f++) begin
            logic [7:0] row;
            logic [7:0] junk;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom);
                if (junk == 8'h4C) junk = 8'h4D;
                send(junk);
            end
            row = 8'($urandom_range(0, 39));
            if (row < 8'd32) begin
                send_frame(row, 2);
            end else begin
                send(8'h4C);
                send(row);
            end
            idle(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
